// File: rtl/rtc_seg_pkg.sv
// Shared types and constants for the multiplexed RTC display demultiplexer.
package rtc_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  localparam int NUM_OF_DIGITS = 6;

  // Active-low segment codes for digits 0..9 with the decimal point dark.
  localparam logic [7:0] CODE_0 = 8'hC0;
  localparam logic [7:0] CODE_1 = 8'hF9;
  localparam logic [7:0] CODE_2 = 8'hA4;
  localparam logic [7:0] CODE_3 = 8'hB0;
  localparam logic [7:0] CODE_4 = 8'h99;
  localparam logic [7:0] CODE_5 = 8'h92;
  localparam logic [7:0] CODE_6 = 8'h82;
  localparam logic [7:0] CODE_7 = 8'hF8;
  localparam logic [7:0] CODE_8 = 8'h80;
  localparam logic [7:0] CODE_9 = 8'h90;

  localparam logic [7:0] BLANK_DIGITS = 8'hFF;

endpackage

// File: rtl/rtc_seg_decode.sv
// Combinational decode of one captured segment code to BCD plus decimal point.
module rtc_seg_decode
  import rtc_seg_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [3:0] o_bcd,
  output logic       o_dp,
  output logic       o_invalid
);

  always_comb begin
    o_invalid = 1'b0;
    o_dp      = ~i_code[7];
    // The ten legal codes all carry a dark dp; anything else is flagged.
    case (i_code)
      CODE_0:  o_bcd = 4'd0;
      CODE_1:  o_bcd = 4'd1;
      CODE_2:  o_bcd = 4'd2;
      CODE_3:  o_bcd = 4'd3;
      CODE_4:  o_bcd = 4'd4;
      CODE_5:  o_bcd = 4'd5;
      CODE_6:  o_bcd = 4'd6;
      CODE_7:  o_bcd = 4'd7;
      CODE_8:  o_bcd = 4'd8;
      CODE_9:  o_bcd = 4'd9;
      default: begin
        o_bcd     = 4'hF;
        o_invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rtc_seg_demux.sv
// Samples a multiplexed 6-digit segment display, debounces each slot and
// publishes complete frames atomically with decode and staleness status.
module rtc_seg_demux
  import rtc_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 1000000
) (
  input  logic        i_sys_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_segments,
  input  logic [7:0]  i_digits,
  output logic [47:0] o_seg_raw,
  output logic [23:0] o_bcd,
  output logic [5:0]  o_dp,
  output logic        o_frame_valid,
  output logic        o_err_pattern,
  output logic        o_err_code,
  output logic        o_stale
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STALE_W  = $clog2(STALE_CYCLES + 1);

  logic [7:0]          seg_in_q, seg_in_d, dig_in_q, dig_in_d;
  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic [5:0]          mask_q, mask_d;
  logic [47:0]         shadow_raw_q, shadow_raw_d;
  logic [23:0]         shadow_bcd_q, shadow_bcd_d;
  logic [5:0]          shadow_dp_q, shadow_dp_d;
  logic [47:0]         seg_raw_q, seg_raw_d;
  logic [23:0]         bcd_q, bcd_d;
  logic [5:0]          dp_q, dp_d;
  logic                frame_valid_q, frame_valid_d;
  logic                err_pattern_q, err_pattern_d;
  logic                err_code_q, err_code_d;
  logic                stale_q, stale_d;

  logic [3:0] cap_bcd;
  logic       cap_dp, cap_invalid;
  logic       changed, is_blank, is_legal, capture, frame_fire;
  logic [5:0] slot_sel;

  rtc_seg_decode u_decode (
    .i_code    (seg_in_q),
    .o_bcd     (cap_bcd),
    .o_dp      (cap_dp),
    .o_invalid (cap_invalid)
  );

  assign slot_sel = ~dig_in_q[NUM_OF_DIGITS-1:0];
  assign is_blank = (dig_in_q == BLANK_DIGITS);
  assign is_legal = (dig_in_q[7:6] == 2'b11) && ($countones(slot_sel) == 1);

  always_comb begin
    seg_in_d      = i_segments;
    dig_in_d      = i_digits;
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    stale_cnt_d   = stale_cnt_q;
    shadow_raw_d  = shadow_raw_q;
    shadow_bcd_d  = shadow_bcd_q;
    shadow_dp_d   = shadow_dp_q;
    seg_raw_d     = seg_raw_q;
    bcd_d         = bcd_q;
    dp_d          = dp_q;
    stale_d       = stale_q;
    frame_valid_d = 1'b0;
    err_pattern_d = 1'b0;
    err_code_d    = 1'b0;
    capture       = 1'b0;
    changed       = ({dig_in_d, seg_in_d} != {dig_in_q, seg_in_q});
    frame_fire    = (mask_q == 6'h3F);
    mask_d        = frame_fire ? 6'h00 : mask_q;

    if (frame_fire) begin
      seg_raw_d     = shadow_raw_q;
      bcd_d         = shadow_bcd_q;
      dp_d          = shadow_dp_q;
      frame_valid_d = 1'b1;
      stale_d       = 1'b0;
    end

    // The classification fires once, on the last cycle of an unbroken settle.
    if (changed) begin
      state_d      = ST_SETTLE;
      settle_cnt_d = '0;
    end else if (state_q == ST_SETTLE) begin
      if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
        if (is_blank) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_HOLD;
          capture       = is_legal;
          err_pattern_d = ~is_legal;
        end
      end else begin
        settle_cnt_d = settle_cnt_q + 1'b1;
      end
    end

    if (capture) begin
      for (int i = 0; i < NUM_OF_DIGITS; i++) begin
        if (slot_sel[i]) begin
          shadow_raw_d[8*i +: 8] = seg_in_q;
          shadow_bcd_d[4*i +: 4] = cap_bcd;
          shadow_dp_d[i]         = cap_dp;
        end
      end
      mask_d     = mask_d | slot_sel;
      err_code_d = cap_invalid;
    end

    if (capture) begin
      stale_cnt_d = '0;
    end else if (stale_cnt_q != STALE_W'(STALE_CYCLES)) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end
    if (!frame_fire && stale_cnt_d == STALE_W'(STALE_CYCLES)) begin
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      seg_in_q      <= 8'hFF;
      dig_in_q      <= BLANK_DIGITS;
      state_q       <= ST_IDLE;
      settle_cnt_q  <= '0;
      stale_cnt_q   <= '0;
      mask_q        <= '0;
      shadow_raw_q  <= '0;
      shadow_bcd_q  <= '0;
      shadow_dp_q   <= '0;
      seg_raw_q     <= 48'hFFFF_FFFF_FFFF;
      bcd_q         <= '0;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      err_pattern_q <= 1'b0;
      err_code_q    <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      seg_in_q      <= seg_in_d;
      dig_in_q      <= dig_in_d;
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      stale_cnt_q   <= stale_cnt_d;
      mask_q        <= mask_d;
      shadow_raw_q  <= shadow_raw_d;
      shadow_bcd_q  <= shadow_bcd_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_raw_q     <= seg_raw_d;
      bcd_q         <= bcd_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      err_pattern_q <= err_pattern_d;
      err_code_q    <= err_code_d;
      stale_q       <= stale_d;
    end
  end

  assign o_seg_raw     = seg_raw_q;
  assign o_bcd         = bcd_q;
  assign o_dp          = dp_q;
  assign o_frame_valid = frame_valid_q;
  assign o_err_pattern = err_pattern_q;
  assign o_err_code    = err_code_q;
  assign o_stale       = stale_q;

endmodule
